// File: rtl/enc16_4_seq.sv
// Sequential 16-to-4 encoder: captures one-cycle request pulses into a pending
// vector and emits them one at a time, in priority order, over valid/ready.
module enc16_4_seq #(
    parameter int LOW_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    input  logic       i3,
    input  logic       i4,
    input  logic       i5,
    input  logic       i6,
    input  logic       i7,
    input  logic       i8,
    input  logic       i9,
    input  logic       i10,
    input  logic       i11,
    input  logic       i12,
    input  logic       i13,
    input  logic       i14,
    input  logic       i15,
    input  logic       ready,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       valid,
    output logic [4:0] cnt,
    output logic       drop
);

    // Later hits overwrite earlier ones, so the scan direction decides priority.
    function automatic logic [3:0] pick(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (LOW_FIRST != 0) begin
                if (v[15-k]) r = 4'(15 - k);
            end else begin
                if (v[k]) r = 4'(k);
            end
        end
        return r;
    endfunction

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] s;
        s = 5'd0;
        for (int k = 0; k < 16; k++) begin
            s = s + {4'd0, v[k]};
        end
        return s;
    endfunction

    logic [15:0] req_s;
    logic [15:0] p_r;
    logic [15:0] p_next_s;
    logic [15:0] grant_s;
    logic [3:0]  idx_s;
    logic [3:0]  idx_r;
    logic        valid_r;
    logic        load_s;
    logic        drop_next_s;
    logic [4:0]  cnt_r;
    logic        drop_r;

    assign req_s = {i15, i14, i13, i12, i11, i10, i9, i8,
                    i7, i6, i5, i4, i3, i2, i1, i0};

    // Load/grant decision and next pending vector; a new request beats a same-bit grant.
    always_comb begin
        idx_s       = pick(p_r);
        load_s      = (!valid_r || ready) && (p_r != 16'd0);
        if (load_s) begin
            grant_s = 16'd1 << idx_s;
        end else begin
            grant_s = 16'd0;
        end
        p_next_s    = (p_r & ~grant_s) | req_s;
        drop_next_s = |(req_s & p_r & ~grant_s);
    end

    // Pending vector, output slot, count and drop registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_r     <= 16'd0;
            idx_r   <= 4'd0;
            valid_r <= 1'b0;
            cnt_r   <= 5'd0;
            drop_r  <= 1'b0;
        end else begin
            p_r    <= p_next_s;
            cnt_r  <= popcount(p_next_s);
            drop_r <= drop_next_s;
            if (load_s) begin
                idx_r   <= idx_s;
                valid_r <= 1'b1;
            end else if (valid_r && ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign {a, b, c, d} = idx_r;
    assign valid        = valid_r;
    assign cnt          = cnt_r;
    assign drop         = drop_r;

endmodule

// File: tb/tb_enc16_4_seq.sv
// Randomized and directed bench for enc16_4_seq; two instances (low-first and
// high-first priority) are checked each cycle against a bit-array reference model.
module tb_enc16_4_seq;

    logic        clk;
    logic        rst;
    logic        ready;
    logic [15:0] req;
    wire  [3:0]  abcd [2];
    wire         valid [2];
    wire  [4:0]  cnt [2];
    wire         drop [2];

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state per instance (0: low-first, 1: high-first)
    bit pm [2][16];
    int om [2];
    bit vm [2];
    int cm [2];
    bit dm [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    enc16_4_seq #(.LOW_FIRST(1)) dut_lo (
        .clk(clk), .rst(rst),
        .i0(req[0]), .i1(req[1]), .i2(req[2]), .i3(req[3]),
        .i4(req[4]), .i5(req[5]), .i6(req[6]), .i7(req[7]),
        .i8(req[8]), .i9(req[9]), .i10(req[10]), .i11(req[11]),
        .i12(req[12]), .i13(req[13]), .i14(req[14]), .i15(req[15]),
        .ready(ready),
        .a(abcd[0][3]), .b(abcd[0][2]), .c(abcd[0][1]), .d(abcd[0][0]),
        .valid(valid[0]), .cnt(cnt[0]), .drop(drop[0])
    );

    enc16_4_seq #(.LOW_FIRST(0)) dut_hi (
        .clk(clk), .rst(rst),
        .i0(req[0]), .i1(req[1]), .i2(req[2]), .i3(req[3]),
        .i4(req[4]), .i5(req[5]), .i6(req[6]), .i7(req[7]),
        .i8(req[8]), .i9(req[9]), .i10(req[10]), .i11(req[11]),
        .i12(req[12]), .i13(req[13]), .i14(req[14]), .i15(req[15]),
        .ready(ready),
        .a(abcd[1][3]), .b(abcd[1][2]), .c(abcd[1][1]), .d(abcd[1][0]),
        .valid(valid[1]), .cnt(cnt[1]), .drop(drop[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference model, from the pre-edge state and inputs.
    task automatic model_edge(input int inst, input logic [15:0] r, input bit rdy, input bit rs);
        bit any;
        int g;
        bit dn;
        int s;
        if (rs) begin
            for (int k = 0; k < 16; k++) pm[inst][k] = 1'b0;
            om[inst] = 0; vm[inst] = 1'b0; cm[inst] = 0; dm[inst] = 1'b0;
            return;
        end
        any = 1'b0;
        for (int k = 0; k < 16; k++) if (pm[inst][k]) any = 1'b1;
        g = -1;
        if ((!vm[inst] || rdy) && any) begin
            if (inst == 0) begin
                for (int k = 15; k >= 0; k--) if (pm[inst][k]) g = k;
            end else begin
                for (int k = 0; k < 16; k++) if (pm[inst][k]) g = k;
            end
        end
        dn = 1'b0;
        for (int k = 0; k < 16; k++) if (r[k] && pm[inst][k] && k != g) dn = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == g) pm[inst][k] = 1'b0;
            if (r[k]) pm[inst][k] = 1'b1;
        end
        if (g >= 0) begin
            om[inst] = g; vm[inst] = 1'b1;
        end else if (vm[inst] && rdy) begin
            vm[inst] = 1'b0;
        end
        s = 0;
        for (int k = 0; k < 16; k++) s += int'(pm[inst][k]);
        cm[inst] = s;
        dm[inst] = dn;
    endtask

    // Apply inputs, clock once, update the models and compare both instances.
    task automatic cyc(input logic [15:0] r, input bit rdy, input bit rs);
        req = r; ready = rdy; rst = rs;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i, r, rdy, rs);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("valid[%0d]", i), int'(valid[i]), int'(vm[i]));
            check($sformatf("abcd[%0d]", i), int'(abcd[i]), om[i]);
            check($sformatf("cnt[%0d]", i), int'(cnt[i]), cm[i]);
            check($sformatf("drop[%0d]", i), int'(drop[i]), int'(dm[i]));
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) cyc(16'd0, 1'b1, 1'b0);
    endtask

    initial begin
        int seen3;
        logic [15:0] r;
        req = 16'd0; ready = 1'b1; rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 16; k++) pm[i][k] = 1'b0;
            om[i] = 0; vm[i] = 1'b0; cm[i] = 0; dm[i] = 1'b0;
        end

        // reset with i3 asserted: index 3 must never appear
        cyc(16'h0008, 1'b1, 1'b1);
        cyc(16'h0008, 1'b1, 1'b1);
        seen3 = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(16'd0, 1'b1, 1'b0);
            if (valid[0] && abcd[0] == 4'd3) seen3++;
        end
        check("rst_valid", int'(valid[0]), 0);
        check("rst_abcd", int'(abcd[0]), 0);
        check("rst_cnt", int'(cnt[0]), 0);
        check("rst_no_idx3", seen3, 0);

        // single request on i5
        cyc(16'h0020, 1'b1, 1'b0);
        check("single_cnt1", int'(cnt[0]), 1);
        check("single_valid_early", int'(valid[0]), 0);
        cyc(16'd0, 1'b1, 1'b0);
        check("single_valid", int'(valid[0]), 1);
        check("single_idx", int'(abcd[0]), 5);
        check("single_cnt0", int'(cnt[0]), 0);
        cyc(16'd0, 1'b1, 1'b0);
        check("single_valid_off", int'(valid[0]), 0);

        // burst i0, i9, i15 together
        cyc(16'h8201, 1'b1, 1'b0);
        check("burst_cnt3", int'(cnt[0]), 3);
        cyc(16'd0, 1'b1, 1'b0);
        check("burst_lo_1", int'(abcd[0]), 0);
        check("burst_hi_1", int'(abcd[1]), 15);
        check("burst_cnt2", int'(cnt[0]), 2);
        cyc(16'd0, 1'b1, 1'b0);
        check("burst_lo_2", int'(abcd[0]), 9);
        check("burst_hi_2", int'(abcd[1]), 9);
        cyc(16'd0, 1'b1, 1'b0);
        check("burst_lo_3", int'(abcd[0]), 15);
        check("burst_hi_3", int'(abcd[1]), 0);
        check("burst_cnt0", int'(cnt[0]), 0);
        cyc(16'd0, 1'b1, 1'b0);
        check("burst_end", int'(valid[0]), 0);

        // backpressure: i2 then i7 with ready low
        cyc(16'h0004, 1'b0, 1'b0);
        cyc(16'h0080, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(16'd0, 1'b0, 1'b0);
        check("bp_hold_idx", int'(abcd[0]), 2);
        check("bp_hold_valid", int'(valid[0]), 1);
        check("bp_hold_cnt", int'(cnt[0]), 1);
        cyc(16'd0, 1'b1, 1'b0);
        check("bp_next_idx", int'(abcd[0]), 7);
        drain();

        // drop and merge: i4 twice, 3 cycles apart, output busy
        cyc(16'h0002, 1'b0, 1'b0);
        cyc(16'd0, 1'b0, 1'b0);
        cyc(16'h0010, 1'b0, 1'b0);
        cyc(16'd0, 1'b0, 1'b0);
        cyc(16'd0, 1'b0, 1'b0);
        cyc(16'h0010, 1'b0, 1'b0);
        check("merge_drop", int'(drop[0]), 1);
        check("merge_cnt", int'(cnt[0]), 1);
        cyc(16'd0, 1'b0, 1'b0);
        check("merge_drop_off", int'(drop[0]), 0);
        drain();

        // set during grant on bit 6
        cyc(16'h0040, 1'b1, 1'b0);
        cyc(16'h0040, 1'b1, 1'b0);
        check("sdg_idx1", int'(abcd[0]), 6);
        check("sdg_drop", int'(drop[0]), 0);
        cyc(16'd0, 1'b1, 1'b0);
        check("sdg_idx2", int'(abcd[0]), 6);
        check("sdg_valid2", int'(valid[0]), 1);
        drain();

        // randomized traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) r = 16'd0;
            cyc(r, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 199) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
